// File: rtl/uart_pkg.sv
// Shared UART constants and types, used by the receiver, the transmitter and the RX FIFO.
package uart_pkg;

    localparam int unsigned UART_DATA_W            = 8;
    localparam int unsigned UART_RX_FIFO_DEPTH_DEF = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Byte storage for the UART RX FIFO: synchronous write port and asynchronous read port.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [UART_DATA_W-1:0] wdata,
    input  logic [AW-1:0]          raddr,
    output logic [UART_DATA_W-1:0] rdata
);

    uart_byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with strobe edge detection and a sticky overrun flag.
// Define UART_RX_FIFO_STATUS_EN to add the level and almost_full status ports.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH     = UART_RX_FIFO_DEPTH_DEF,
    parameter int unsigned AFULL_LVL = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [UART_DATA_W-1:0]   wr_data,
    input  logic                     wr_strobe,
    output logic [UART_DATA_W-1:0]   rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    input  logic                     overrun_clr,
`ifdef UART_RX_FIFO_STATUS_EN
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
`endif
    output logic                     overrun
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
        AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_param_check
        $error("uart_rx_fifo: illegal DEPTH or AFULL_LVL");
    end

    logic          strobe_q;
    logic          armed;
    logic          push_edge;
    logic          do_push;
    logic          pop;
    logic          full;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    uart_byte_t    ram_rdata;

    // armed stays low after reset until wr_strobe is seen low, so a strobe
    // already high across reset release cannot fake a rising edge.
    always_comb begin
        push_edge = wr_strobe & ~strobe_q & armed;
        rd_valid  = (count != '0);
        full      = (count == FULL_CNT);
        pop       = rd_valid & rd_ready;
        do_push   = push_edge & (~full | pop);
        rd_data   = rd_valid ? ram_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_q <= 1'b0;
            armed    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overrun  <= 1'b0;
        end else begin
            strobe_q <= wr_strobe;
            if (!wr_strobe) begin
                armed <= 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_edge && full && !pop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_STATUS_EN
    always_comb begin
        level       = count;
        almost_full = (count >= CW'(AFULL_LVL));
    end
`endif

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (do_push & ~reset),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo (DEPTH=16, AFULL_LVL=12); status ports checked when UART_RX_FIFO_STATUS_EN is defined.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_strobe = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic       overrun_clr = 1'b0;
    logic       overrun;
`ifdef UART_RX_FIFO_STATUS_EN
    logic [4:0] level;
    logic       almost_full;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  sb[$];
    logic        exp_ovr = 1'b0;

    uart_rx_fifo #(
        .DEPTH     (16),
        .AFULL_LVL (12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_data     (wr_data),
        .wr_strobe   (wr_strobe),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .overrun_clr (overrun_clr),
`ifdef UART_RX_FIFO_STATUS_EN
        .level       (level),
        .almost_full (almost_full),
`endif
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr_strobe = 1'b0;
        tick();
        sb.delete();
        exp_ovr = 1'b0;
    endtask

    // One strobe pulse; the model records where the byte should end up.
    task automatic pulse(input logic [7:0] d);
        wr_data = d;
        wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
        tick();
        if (sb.size() < 16) sb.push_back(d);
        else exp_ovr = 1'b1;
    endtask

    task automatic pop_one(output logic [7:0] d, output logic v);
        v = rd_valid;
        d = rd_data;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        wr_strobe = 1'b1;
        wr_data = 8'hFF;
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got valid=%b data=%h ovr=%b want 0/00/0", rd_valid, rd_data, overrun);
        end
`ifdef UART_RX_FIFO_STATUS_EN
        total++;
        if (level !== 5'd0 || almost_full !== 1'b0) begin
            bad++;
            $display("FAIL reset_status got level=%0d afull=%b want 0/0", level, almost_full);
        end
`endif
        do_reset();
    endtask

    task automatic test_single();
        logic [7:0] exp;
        wr_data = 8'hA5;
        wr_strobe = 1'b1;
        sb.push_back(8'hA5);
        tick();
        wr_strobe = 1'b0;
        exp = sb.pop_front();
        total++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            bad++;
            $display("FAIL single_latency got valid=%b data=%h want 1/%h", rd_valid, rd_data, exp);
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        total++;
        if (rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_pop got valid=%b want 0", rd_valid);
        end
    endtask

    task automatic test_hold();
        logic [7:0] got, exp;
        logic v;
        wr_data = 8'h3C;
        wr_strobe = 1'b1;
        sb.push_back(8'h3C);
        repeat (5) tick();
        wr_strobe = 1'b0;
        tick();
`ifdef UART_RX_FIFO_STATUS_EN
        total++;
        if (level !== 5'd1) begin
            bad++;
            $display("FAIL hold_level got %0d want 1", level);
        end
`endif
        pop_one(got, v);
        exp = sb.pop_front();
        total++;
        if (v !== 1'b1 || got !== exp) begin
            bad++;
            $display("FAIL hold_data got valid=%b data=%h want 1/%h", v, got, exp);
        end
        total++;
        if (rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_single_entry got valid=%b want 0", rd_valid);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] got, exp, head;
        logic v;
        for (int i = 0; i < 17; i++) pulse(8'(i));
        total++;
        if (overrun !== exp_ovr || rd_valid !== 1'b1) begin
            bad++;
            $display("FAIL overrun_set got ovr=%b valid=%b want %b/1", overrun, rd_valid, exp_ovr);
        end
`ifdef UART_RX_FIFO_STATUS_EN
        total++;
        if (level !== 5'd16) begin
            bad++;
            $display("FAIL overrun_level got %0d want 16", level);
        end
`endif
        head = rd_data;
        repeat (3) tick();
        total++;
        if (rd_data !== head || rd_data !== sb[0]) begin
            bad++;
            $display("FAIL stall_stable got %h want %h", rd_data, sb[0]);
        end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            pop_one(got, v);
            total++;
            if (v !== 1'b1 || got !== exp) begin
                bad++;
                $display("FAIL overrun_drain got valid=%b data=%h want 1/%h", v, got, exp);
            end
        end
        total++;
        if (rd_valid !== 1'b0 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_sticky got valid=%b ovr=%b want 0/1", rd_valid, overrun);
        end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        exp_ovr = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clear got %b want 0", overrun);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] got, exp;
        logic v;
        for (int i = 0; i < 16; i++) pulse(8'h20 + 8'(i));
        exp = sb.pop_front();
        total++;
        if (rd_data !== exp) begin
            bad++;
            $display("FAIL full_head got %h want %h", rd_data, exp);
        end
        wr_data = 8'h77;
        wr_strobe = 1'b1;
        rd_ready = 1'b1;
        sb.push_back(8'h77);
        tick();
        wr_strobe = 1'b0;
        rd_ready = 1'b0;
        tick();
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL full_pushpop_ovr got %b want 0", overrun);
        end
`ifdef UART_RX_FIFO_STATUS_EN
        total++;
        if (level !== 5'd16) begin
            bad++;
            $display("FAIL full_pushpop_level got %0d want 16", level);
        end
`endif
        // Overrun and clear in the same cycle: the new overrun wins.
        wr_data = 8'h55;
        wr_strobe = 1'b1;
        overrun_clr = 1'b1;
        tick();
        wr_strobe = 1'b0;
        overrun_clr = 1'b0;
        tick();
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_clr_race got %b want 1", overrun);
        end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            pop_one(got, v);
            total++;
            if (v !== 1'b1 || got !== exp) begin
                bad++;
                $display("FAIL full_drain got valid=%b data=%h want 1/%h", v, got, exp);
            end
        end
    endtask

    task automatic test_afull();
        logic [7:0] got, exp;
        logic v;
        for (int i = 0; i < 11; i++) pulse(8'h60 + 8'(i));
`ifdef UART_RX_FIFO_STATUS_EN
        total++;
        if (almost_full !== 1'b0 || level !== 5'd11) begin
            bad++;
            $display("FAIL afull_11 got afull=%b level=%0d want 0/11", almost_full, level);
        end
`endif
        pulse(8'h6B);
`ifdef UART_RX_FIFO_STATUS_EN
        total++;
        if (almost_full !== 1'b1 || level !== 5'd12) begin
            bad++;
            $display("FAIL afull_12 got afull=%b level=%0d want 1/12", almost_full, level);
        end
`endif
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            pop_one(got, v);
            total++;
            if (v !== 1'b1 || got !== exp) begin
                bad++;
                $display("FAIL afull_drain got valid=%b data=%h want 1/%h", v, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'h41 + 8'(i);
            wr_strobe = 1'b1;
            sb.push_back(wr_data);
            tick();
            wr_strobe = 1'b0;
            exp = sb.pop_front();
            total++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                bad++;
                $display("FAIL b2b_out%0d got valid=%b data=%h want 1/%h", i, rd_valid, rd_data, exp);
            end
            tick();
            total++;
            if (rd_valid !== 1'b0) begin
                bad++;
                $display("FAIL b2b_empty%0d got valid=%b want 0", i, rd_valid);
            end
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) pulse(8'h90 + 8'(i));
        wr_data = 8'h99;
        wr_strobe = 1'b1;
        reset = 1'b1;
        rd_ready = 1'b1;
        tick();
        reset = 1'b0;
        rd_ready = 1'b0;
        sb.delete();
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            bad++;
            $display("FAIL midreset_state got valid=%b data=%h want 0/00", rd_valid, rd_data);
        end
`ifdef UART_RX_FIFO_STATUS_EN
        total++;
        if (level !== 5'd0) begin
            bad++;
            $display("FAIL midreset_level got %0d want 0", level);
        end
`endif
        repeat (4) tick();
        total++;
        if (rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL held_strobe_nowrite got valid=%b want 0", rd_valid);
        end
        wr_strobe = 1'b0;
        tick();
        wr_strobe = 1'b1;
        sb.push_back(8'h99);
        tick();
        wr_strobe = 1'b0;
        total++;
        if (rd_valid !== 1'b1 || rd_data !== sb[0]) begin
            bad++;
            $display("FAIL rearm_push got valid=%b data=%h want 1/%h", rd_valid, rd_data, sb[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_overrun();
        test_full_push_pop();
        test_afull();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
